// File: rtl/ds_lsu_pkg.sv
// Shared constants and types for the DS-form doubleword load/store sequencer.
// State codes are plain localparams so legacy netlists and waveforms keep their encoding.
package ds_lsu_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_DECODE = 3'd1;
  localparam state_t S_EA     = 3'd2;
  localparam state_t S_MEM    = 3'd3;
  localparam state_t S_WB     = 3'd4;
  localparam state_t S_DONE   = 3'd5;

  localparam logic [5:0] PO_LD  = 6'b111010;
  localparam logic [5:0] PO_STD = 6'b111110;
  localparam logic [1:0] XO_D   = 2'b00;

  typedef enum logic {
    OP_LD  = 1'b0,
    OP_STD = 1'b1
  } op_kind_t;

endpackage

// File: rtl/ds_lsu_if.sv
// Data-memory req/ack port between the LSU controller (master) and the memory (slave).
interface ds_lsu_if #(
  parameter int XLEN   = 64,
  parameter int MEM_AW = 6
);
  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/ds_ea_calc.sv
// DS-form effective address: (RA|0) + sext(ds||00), plus a doubleword misalignment flag.
module ds_ea_calc #(
  parameter int XLEN = 64
) (
  input  logic [4:0]      ra,
  input  logic [XLEN-1:0] ra_data,
  input  logic [13:0]     ds,
  output logic [XLEN-1:0] ea,
  output logic            misaligned
);
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] offset;

  // Register 0 as a base means the literal value zero, not the contents of r0.
  assign base       = (ra == 5'd0) ? '0 : ra_data;
  assign offset     = {{(XLEN-16){ds[13]}}, ds, 2'b00};
  assign ea         = base + offset;
  assign misaligned = |ea[2:0];
endmodule

// File: rtl/ds_lsu_controller.sv
// Multi-cycle sequencer for DS-form ld/std: decode, EA, req/ack memory access, writeback.
// Define LSU_ALIGN_CHECK_EN to add the fault port and abort misaligned accesses before MEM.
module ds_lsu_controller
  import ds_lsu_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int MEM_AW      = 6,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [5:0]      po,
  input  logic [1:0]      xo,
  input  logic [4:0]      rt,
  input  logic [4:0]      ra,
  input  logic [13:0]     ds,
  output logic [4:0]      rf_ra_addr,
  input  logic [XLEN-1:0] rf_ra_data,
  output logic [4:0]      rf_rt_addr,
  input  logic [XLEN-1:0] rf_rt_data,
  output logic            rf_we,
  output logic [4:0]      rf_wa,
  output logic [XLEN-1:0] rf_wd,
  ds_lsu_if.master        mem,
  output logic            busy,
  output logic            done,
  output logic            illegal,
`ifdef LSU_ALIGN_CHECK_EN
  output logic            fault,
`endif
  output logic            timeout
);
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t          state_q;
  op_kind_t        op_q;
  logic [5:0]      po_q;
  logic [1:0]      xo_q;
  logic [4:0]      rt_q;
  logic [4:0]      ra_q;
  logic [13:0]     ds_q;
  logic [XLEN-1:0] ea_q;
  logic [XLEN-1:0] st_data_q;
  logic [XLEN-1:0] ld_data_q;
  logic [7:0]      cnt_q;

  logic [XLEN-1:0] ea;
  logic            misaligned;
  logic            decode_ok;
  logic            in_mem;
  logic            abort_ea;
  logic            unused_bits;

  ds_ea_calc #(.XLEN(XLEN)) u_ea_calc (
    .ra         (ra_q),
    .ra_data    (rf_ra_data),
    .ds         (ds_q),
    .ea         (ea),
    .misaligned (misaligned)
  );

  assign decode_ok = (po_q == PO_LD || po_q == PO_STD) && (xo_q == XO_D);
  assign in_mem    = (state_q == S_MEM);

`ifdef LSU_ALIGN_CHECK_EN
  assign abort_ea    = misaligned;
  assign fault       = (state_q == S_EA) && misaligned;
  assign unused_bits = ^{ea_q[XLEN-1:MEM_AW+3], ea_q[2:0]};
`else
  assign abort_ea    = 1'b0;
  assign unused_bits = ^{ea_q[XLEN-1:MEM_AW+3], ea_q[2:0], misaligned};
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_LD;
      po_q      <= '0;
      xo_q      <= '0;
      rt_q      <= '0;
      ra_q      <= '0;
      ds_q      <= '0;
      ea_q      <= '0;
      st_data_q <= '0;
      ld_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (instr_valid) begin
          po_q    <= po;
          xo_q    <= xo;
          rt_q    <= rt;
          ra_q    <= ra;
          ds_q    <= ds;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          op_q    <= (po_q == PO_STD) ? OP_STD : OP_LD;
          state_q <= decode_ok ? S_EA : S_IDLE;
        end
        S_EA: begin
          ea_q  <= ea;
          cnt_q <= '0;
          if (op_q == OP_STD) st_data_q <= rf_rt_data;
          state_q <= abort_ea ? S_IDLE : S_MEM;
        end
        S_MEM: begin
          if (mem.mem_ack) begin
            if (op_q == OP_LD) ld_data_q <= mem.mem_rdata;
            state_q <= (op_q == OP_LD) ? S_WB : S_DONE;
          end else if (cnt_q == TO_LAST) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Request is decoded from state so an asynchronous reset drops it without waiting for a clock.
  assign instr_ready   = (state_q == S_IDLE);
  assign busy          = ~instr_ready;
  assign rf_ra_addr    = ra_q;
  assign rf_rt_addr    = rt_q;
  assign mem.mem_req   = in_mem;
  assign mem.mem_we    = in_mem && (op_q == OP_STD);
  assign mem.mem_addr  = ea_q[MEM_AW+2:3];
  assign mem.mem_wdata = st_data_q;
  assign rf_we         = (state_q == S_WB);
  assign rf_wa         = rt_q;
  assign rf_wd         = ld_data_q;
  assign done          = (state_q == S_WB) || (state_q == S_DONE);
  assign illegal       = (state_q == S_DECODE) && !decode_ok;
  assign timeout       = in_mem && !mem.mem_ack && (cnt_q == TO_LAST);
endmodule
